data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder for the pipelined core: the target end of the core's M_ADDR / D_IN / D_OUT data-memory interface.
- Accepts one word-addressed read or write per request and returns an ACK after a programmable number of wait states.
- Word storage sits in a dedicated array sub-module; this block owns the handshake, latency counter and address check.

Parameters:
- ADDR_W, 10, word-address bits actually decoded (DEPTH = 2**ADDR_W words)
- DATA_W, 32, data word width
- WAIT_CYC, 0, wait states inserted between request accept and ACK (0..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- REQ  in  1  request strobe from core
- MW  in  1  1 = write, 0 = read; sampled with REQ
- M_ADDR  in  32  word address; sampled with REQ
- D_IN  in  DATA_W  write data; sampled with REQ
- READY  out  1  responder can accept a request this cycle
- ACK  out  1  one-cycle completion pulse
- D_OUT  out  DATA_W  read data, valid only while ACK=1 for a read
- ERR  out  1  address out of range, valid with ACK

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, READY=1, ACK=0, ERR=0, D_OUT=0. Array contents are not cleared.
- States:
  - IDLE: READY=1. REQ&READY latches MW, M_ADDR, D_IN. Goes to WAIT if WAIT_CYC>0, else to ACCESS.
  - WAIT: READY=0. Counter loads WAIT_CYC-1 on accept and decrements each cycle; at 0, goes to ACCESS.
  - ACCESS: READY=0.
    - Write: array written with latched data.
    - Read: array read, synchronous, data registered.
    - Next state is RESP.
  - RESP: ACK=1 for exactly one cycle and READY=1.
    - REQ in RESP is accepted (back-to-back) and follows the IDLE transition.
    - Otherwise returns to IDLE.
- Latency: accept edge to ACK = WAIT_CYC+2 cycles. Peak throughput is one request per WAIT_CYC+2 cycles.
- D_OUT:
  - Read ACK: array word at latched address.
  - Write ACK: D_OUT=0.
  - D_OUT holds 0 whenever ACK=0.
- Read-after-write to the same address in the next request returns the new data; no bypass is needed since requests serialize.
- REQ while READY=0 is ignored, not queued. The core must hold REQ until it observes READY.
- M_ADDR bits above ADDR_W: handled per Optional Feature.
- Reset mid-operation (WAIT or ACCESS): request aborted, no ACK issued. A write not yet in ACCESS is not committed. A write whose ACCESS edge coincides with reset assertion is undefined.
- Counter wrap: impossible by construction. WAIT_CYC>15 is rejected at elaboration.

Optional Feature:
- Macro: DMEM_RANGE_CHK_EN.
- Defined: if M_ADDR[31:ADDR_W] != 0 at accept, ERR=1 with ACK, the write is suppressed and read D_OUT=0. ERR=0 on every other ACK.
- Undefined: upper bits are ignored, so addresses alias modulo DEPTH. ERR is tied 0.

Decomposition:
- Package dmem_pkg: state enum (IDLE, WAIT, ACCESS, RESP, 2-bit), default ADDR_W/DATA_W, WAIT_CYC maximum of 15.
- Sub-module dmem_array: DEPTH x DATA_W.
  - Ports: clk, we, addr, wdata, rdata.
  - Synchronous write, registered read, no reset.

Test Plan:
- WAIT_CYC=0: write 0x0000_00A5 to addr 3, then read addr 3 -> read ACK 2 cycles after accept, D_OUT=0x0000_00A5, ERR=0.
- WAIT_CYC=3: read addr 7 after writing 0xDEAD_BEEF -> ACK exactly 5 cycles after accept; READY=0 for the 4 intervening cycles.
- Back-to-back: REQ held high across three reads of addr 0,1,2 (preloaded 0x10,0x11,0x12) -> second and third requests accepted in RESP cycles; ACKs every 2 cycles carry 0x10,0x11,0x12.
- Busy drop: REQ pulsed one cycle in WAIT (write 0xFFFF_FFFF to addr 5) -> ignored; addr 5 retains its prior value 0x0.
- Reset mid-WAIT (WAIT_CYC=4, write 0x1234 to addr 9, rst_n low at cycle 2) -> no ACK; READY=1 immediately; subsequent read of addr 9 returns the old value.
- DMEM_RANGE_CHK_EN on: write to M_ADDR=0x0000_0400 (ADDR_W=10) -> ACK with ERR=1; addr 0 unchanged. With macro off, the same write lands in addr 0 with ERR=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared state encoding, default widths and wait-state limit for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  localparam int DMEM_ADDR_W_DEF   = 10;
  localparam int DMEM_DATA_W_DEF   = 32;
  localparam int DMEM_WAIT_CYC_MAX = 15;
  localparam int DMEM_CNT_W        = 4;

  // Value loaded into the wait counter on accept; the counter is unused when there are no wait states.
  function automatic logic [DMEM_CNT_W-1:0] wait_load(input int wait_cyc);
    return (wait_cyc > 0) ? DMEM_CNT_W'(wait_cyc - 1) : '0;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-side data-memory bus: request/address/data towards the responder, READY/ACK/data/ERR back.
interface data_mem_responder_if import dmem_pkg::*; #(
  parameter int DATA_W = DMEM_DATA_W_DEF
) ();

  logic              REQ;
  logic              MW;
  logic [31:0]       M_ADDR;
  logic [DATA_W-1:0] D_IN;
  logic              READY;
  logic              ACK;
  logic [DATA_W-1:0] D_OUT;
  logic              ERR;

  modport master (
    output REQ, MW, M_ADDR, D_IN,
    input  READY, ACK, D_OUT, ERR
  );

  modport slave (
    input  REQ, MW, M_ADDR, D_IN,
    output READY, ACK, D_OUT, ERR
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous write, registered read, contents never reset.
module dmem_array import dmem_pkg::*; #(
  parameter int ADDR_W = DMEM_ADDR_W_DEF,
  parameter int DATA_W = DMEM_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word read/write per request and ACKs after WAIT_CYC+2 cycles.
// Optional upper-address range check enabled by defining DMEM_RANGE_CHK_EN.
module data_mem_responder import dmem_pkg::*; #(
  parameter int ADDR_W   = DMEM_ADDR_W_DEF,
  parameter int DATA_W   = DMEM_DATA_W_DEF,
  parameter int WAIT_CYC = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  if (WAIT_CYC < 0 || WAIT_CYC > DMEM_WAIT_CYC_MAX) begin : g_bad_wait_cyc
    $error("data_mem_responder: WAIT_CYC must be in 0..15");
  end
  if (ADDR_W < 1 || ADDR_W > 31) begin : g_bad_addr_w
    $error("data_mem_responder: ADDR_W must be in 1..31");
  end

  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYC);

  dmem_state_e           state_q;
  logic [DMEM_CNT_W-1:0] cnt_q;
  logic                  mw_q;
  logic                  oor_q;
  logic                  ready_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  rd_ok_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata;
  logic                  accept;
  logic                  oor_in;
  logic                  mem_we;

  assign accept = bus.REQ && ready_q;

`ifdef DMEM_RANGE_CHK_EN
  assign oor_in = |bus.M_ADDR[31:ADDR_W];
`else
  // Upper address bits are ignored, so addresses alias modulo the array depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.M_ADDR[31:ADDR_W];
  assign oor_in         = 1'b0;
`endif

  // Control FSM; READY/ACK/ERR are registered so they change only on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mw_q    <= 1'b0;
      oor_q   <= 1'b0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            mw_q    <= bus.MW;
            oor_q   <= oor_in;
            cnt_q   <= CNT_LOAD;
            ready_q <= 1'b0;
            state_q <= (WAIT_CYC > 0) ? WAIT : ACCESS;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ACCESS;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          ready_q <= 1'b1;
          ack_q   <= 1'b1;
          err_q   <= oor_q;
          rd_ok_q <= !mw_q && !oor_q;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Request payload is captured on accept and needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.M_ADDR[ADDR_W-1:0];
      wdata_q <= bus.D_IN;
    end
  end

  assign mem_we = (state_q == ACCESS) && mw_q && !oor_q;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // Read data is exposed only during a clean read ACK and is zero otherwise.
  assign bus.D_OUT = rd_ok_q ? rdata : '0;
  assign bus.READY = ready_q;
  assign bus.ACK   = ack_q;
  assign bus.ERR   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances with WAIT_CYC = 0, 3 and 4.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0]       rst_n;
  logic [ND-1:0]       req;
  logic [ND-1:0]       mw;
  logic [ND-1:0][31:0] maddr;
  logic [ND-1:0][31:0] din;
  logic [ND-1:0]       rdy;
  logic [ND-1:0]       ack;
  logic [ND-1:0][31:0] dout;
  logic [ND-1:0]       err;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t exp_q [ND][$];

  function automatic int wc_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : (g == 1) ? 3 : 4;

    data_mem_responder_if #(.DATA_W(32)) bus ();

    assign bus.REQ    = req[g];
    assign bus.MW     = mw[g];
    assign bus.M_ADDR = maddr[g];
    assign bus.D_IN   = din[g];
    assign rdy[g]     = bus.READY;
    assign ack[g]     = bus.ACK;
    assign dout[g]    = bus.D_OUT;
    assign err[g]     = bus.ERR;

    data_mem_responder #(
      .ADDR_W   (10),
      .DATA_W   (32),
      .WAIT_CYC (WC)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n[g]),
      .bus   (bus.slave)
    );

    // Monitor: pops one expectation per ACK, otherwise D_OUT must idle at zero.
    always @(negedge clk) begin
      exp_t e;
      if (ack[g] === 1'b1) begin
        if (exp_q[g].size() == 0) begin
          chk($sformatf("dut%0d unexpected ACK", g), 64'd1, 64'd0);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("dut%0d D_OUT", g), dout[g], e.data);
          chk($sformatf("dut%0d ERR", g), err[g], e.err);
          chk($sformatf("dut%0d ACK cycle", g), cyc, e.due);
        end
      end else begin
        chk($sformatf("dut%0d D_OUT idle", g), dout[g], 64'd0);
      end
    end
  end

  // Drives one request from a negedge and returns at the negedge after the accept edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input bit hold, input bit expect_ack,
                       output int acc);
    int   n;
    exp_t e;
    n = 0;
    req[d]   = 1'b1;
    mw[d]    = w;
    maddr[d] = a;
    din[d]   = wd;
    while (rdy[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d READY within budget", d), 64'(n < 50), 64'd1);
    acc = cyc;
    @(posedge clk);
    if (expect_ack) begin
      e.data = ed;
      e.err  = ee;
      e.due  = acc + wc_of(d) + 2;
      exp_q[d].push_back(e);
    end
    @(negedge clk);
    if (!hold) req[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, k;
    rst_n = '0;
    req   = '0;
    mw    = '0;
    maddr = '0;
    din   = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("dut%0d reset READY", d), rdy[d], 64'd1);
      chk($sformatf("dut%0d reset ACK", d), ack[d], 64'd0);
      chk($sformatf("dut%0d reset ERR", d), err[d], 64'd0);
      chk($sformatf("dut%0d reset D_OUT", d), dout[d], 64'd0);
    end
    rst_n = '1;
    @(negedge clk);

    // WAIT_CYC=0: write then read back, then preload and back-to-back reads.
    issue(0, 1'b1, 32'd3, 32'h0000_00A5, 32'h0, 1'b0, 1'b0, 1'b1, k);
    issue(0, 1'b0, 32'd3, 32'h0, 32'h0000_00A5, 1'b0, 1'b0, 1'b1, k);
    issue(0, 1'b1, 32'd0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, k);
    issue(0, 1'b1, 32'd1, 32'h11, 32'h0, 1'b0, 1'b0, 1'b1, k);
    issue(0, 1'b1, 32'd2, 32'h12, 32'h0, 1'b0, 1'b0, 1'b1, k);
    issue(0, 1'b0, 32'd0, 32'h0, 32'h10, 1'b0, 1'b1, 1'b1, a0);
    issue(0, 1'b0, 32'd1, 32'h0, 32'h11, 1'b0, 1'b1, 1'b1, a1);
    issue(0, 1'b0, 32'd2, 32'h0, 32'h12, 1'b0, 1'b0, 1'b1, a2);
    chk("b2b accept spacing 1", 64'(a1 - a0), 64'd2);
    chk("b2b accept spacing 2", 64'(a2 - a1), 64'd2);

`ifdef DMEM_RANGE_CHK_EN
    issue(0, 1'b1, 32'h0000_0400, 32'h5A5A_5A5A, 32'h0, 1'b1, 1'b0, 1'b1, k);
    issue(0, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, k);
    issue(0, 1'b0, 32'd0, 32'h0, 32'h10, 1'b0, 1'b0, 1'b1, k);
`else
    issue(0, 1'b1, 32'h0000_0400, 32'h5A5A_5A5A, 32'h0, 1'b0, 1'b0, 1'b1, k);
    issue(0, 1'b0, 32'd0, 32'h0, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b1, k);
`endif

    // WAIT_CYC=3: latency and READY low through WAIT/ACCESS.
    issue(1, 1'b1, 32'd7, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b1, k);
    issue(1, 1'b0, 32'd7, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, k);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dut1 READY low busy cycle %0d", i), rdy[1], 64'd0);
      @(negedge clk);
    end
    chk("dut1 READY in RESP", rdy[1], 64'd1);
    chk("dut1 ACK at accept+5", ack[1], 64'd1);

    // Busy drop: a one-cycle write pulse during WAIT must be ignored.
    issue(1, 1'b1, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, k);
    issue(1, 1'b0, 32'd7, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, k);
    req[1]   = 1'b1;
    mw[1]    = 1'b1;
    maddr[1] = 32'd5;
    din[1]   = 32'hFFFF_FFFF;
    @(negedge clk);
    req[1] = 1'b0;
    issue(1, 1'b0, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, k);

    // WAIT_CYC=4: reset in WAIT aborts the write without an ACK.
    issue(2, 1'b1, 32'd9, 32'h0000_0BAD, 32'h0, 1'b0, 1'b0, 1'b1, k);
    issue(2, 1'b1, 32'd9, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1'b0, k);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("dut2 READY on mid-WAIT reset", rdy[2], 64'd1);
    chk("dut2 no ACK on mid-WAIT reset", ack[2], 64'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (8) @(negedge clk);
    issue(2, 1'b0, 32'd9, 32'h0, 32'h0000_0BAD, 1'b0, 1'b0, 1'b1, k);

    repeat (12) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("dut%0d outstanding ACKs", d), 64'(exp_q[d].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
